// File: rtl/mux_gate_pkg.sv
// Shared definitions for the round-robin scheduler and its bit-serial mux gate.
package mux_gate_pkg;
  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sched_state_t;
endpackage

// File: rtl/mux2.sv
// Generic 1-bit 2:1 multiplexer; the only primitive the gate unit is built from.
module mux2 (
  input  logic i_sel,
  input  logic i_d0,
  input  logic i_d1,
  output logic o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mux_gate_bit.sv
// One-bit AND/OR/XOR/XNOR gate made only of 2:1 muxes; operand A acts as the select.
module mux_gate_bit
  import mux_gate_pkg::*;
(
  input  logic            i_a,
  input  logic            i_b,
  input  logic [OP_W-1:0] i_op,
  output logic            o_y
);
  logic w_nb, w_and, w_or, w_xor, w_xnor, w_lo, w_hi;

  // Inverter realised as b ? 0 : 1 so no logic outside the mux primitive is needed.
  mux2 u_inv  (.i_sel(i_b), .i_d0(1'b1), .i_d1(1'b0), .o_y(w_nb));
  mux2 u_and  (.i_sel(i_a), .i_d0(1'b0), .i_d1(i_b),  .o_y(w_and));
  mux2 u_or   (.i_sel(i_a), .i_d0(i_b),  .i_d1(1'b1), .o_y(w_or));
  mux2 u_xor  (.i_sel(i_a), .i_d0(i_b),  .i_d1(w_nb), .o_y(w_xor));
  mux2 u_xnor (.i_sel(i_a), .i_d0(w_nb), .i_d1(i_b),  .o_y(w_xnor));

  mux2 u_sel_lo (.i_sel(i_op[0]), .i_d0(w_and), .i_d1(w_or),   .o_y(w_lo));
  mux2 u_sel_hi (.i_sel(i_op[0]), .i_d0(w_xor), .i_d1(w_xnor), .o_y(w_hi));
  mux2 u_sel    (.i_sel(i_op[1]), .i_d0(w_lo),  .i_d1(w_hi),   .o_y(o_y));
endmodule

// File: rtl/mux_gate_sched.sv
// Round-robin scheduler sharing one bit-serial mux gate among N_REQ requesters;
// results leave LSB-first-evaluated through a registered valid/ready response port.
module mux_gate_sched
  import mux_gate_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ*OP_W-1:0]      req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sched_state_t     r_state, w_state_next;
  logic [ID_W-1:0]  r_rr_ptr, r_id, w_win;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_rsp_data, w_res_next;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_bit;
  logic             w_any, w_gate, w_accept, w_last;
  logic [ID_W-1:0]  w_src [N_REQ];
  logic [N_REQ-1:0] w_rot;

  // Rotate the request vector so position 0 is the requester at rr_ptr; w_src maps back.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [ID_W:0] w_sum;
    assign w_sum       = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
    assign w_src[gi]   = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                     : ID_W'(w_sum);
    assign w_rot[gi]   = req_valid[w_src[gi]];
  end

  always_comb begin
    w_any = 1'b0;
    w_win = r_rr_ptr;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_win = w_src[j];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_last    = (r_bit == CNT_W'(WIDTH - 1));
  assign req_ready = (w_accept && !rst) ? (N_REQ'(1) << w_win) : '0;

  mux_gate_bit u_gate (
    .i_a  (r_a[r_bit]),
    .i_b  (r_b[r_bit]),
    .i_op (r_op),
    .o_y  (w_gate)
  );

  always_comb begin
    w_res_next        = r_res;
    w_res_next[r_bit] = w_gate;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any)     w_state_next = BUSY;
      BUSY:    if (w_last)    w_state_next = DONE;
      DONE:    if (rsp_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_AND;
      r_bit      <= '0;
      r_res      <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_a      <= req_a[w_win*WIDTH +: WIDTH];
      r_b      <= req_b[w_win*WIDTH +: WIDTH];
      r_op     <= req_op[w_win*OP_W +: OP_W];
      r_id     <= w_win;
      r_bit    <= '0;
      r_res    <= '0;
      r_rr_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end else if (r_state == BUSY) begin
      r_res <= w_res_next;
      r_bit <= r_bit + 1'b1;
      // The response word is only updated here, so it stays frozen through DONE.
      if (w_last) r_rsp_data <= w_res_next;
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_id;
endmodule

// File: tb/tb_mux_gate_sched.sv
// Scoreboard bench for mux_gate_sched: expected results are queued at stimulus time
// and compared when the response handshake completes.
module tb_mux_gate_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];

  mux_gate_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [W-1:0] gate(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
    req_op[id*2 +: 2] = op;
  endtask

  task automatic expect_rsp(input int id, input logic [W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input int id);
    bit got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    for (int c = 0; c < 400 && grant_q.size() < n; c++) @(negedge clk);
    chk("grants_seen", 32'(grant_q.size() >= n), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !rsp_valid) ok = 1'b1;
    end
    chk("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input int idx, input int exp_id);
    int g;
    g = (idx < grant_q.size()) ? grant_q[idx] : -1;
    chk("grant_order", 32'(g), 32'(exp_id));
  endtask

  // Monitor: logs grants and retires scoreboard entries on each response handshake.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
    if (rsp_valid && rsp_ready && !rst) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e_mon = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e_mon.id));
        chk("rsp_data", 32'(rsp_data), 32'(e_mon.data));
        $display("rsp id=%0d data=0x%02h", rsp_id, rsp_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d0;
    logic [1:0]   i0;
    logic [W-1:0] op_exp [4];
    int           lat;
    bit           seen;

    op_exp[0] = 8'hC0; op_exp[1] = 8'hFC; op_exp[2] = 8'h3C; op_exp[3] = 8'hC3;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = 8'(8'h3C + i * 17);
      rb[i] = 8'(8'hA6 - i * 29);
      set_req(i, ra[i], rb[i], 2'(i));
    end

    // Reset values with every requester already valid.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);

    // Round-robin with all four requesters continuously valid.
    expect_rsp(0, gate(ra[0], rb[0], 2'd0));
    expect_rsp(1, gate(ra[1], rb[1], 2'd1));
    expect_rsp(2, gate(ra[2], rb[2], 2'd2));
    expect_rsp(3, gate(ra[3], rb[3], 2'd3));
    expect_rsp(0, gate(ra[0], rb[0], 2'd0));
    @(posedge clk);
    #1 rst = 1'b0;
    wait_grants(5);
    chk_grant(0, 0); chk_grant(1, 1); chk_grant(2, 2); chk_grant(3, 3); chk_grant(4, 0);
    wait_drain();

    // Only requesters 1 and 3 valid; pointer sits at 1.
    grant_q.delete();
    expect_rsp(1, gate(ra[1], rb[1], 2'd1));
    expect_rsp(3, gate(ra[3], rb[3], 2'd3));
    req_valid = 4'b1010;
    wait_grants(2);
    chk_grant(0, 1); chk_grant(1, 3);
    wait_drain();

    // Single XOR request from requester 2 with latency measurement.
    set_req(2, 8'hA5, 8'h3C, 2'b10);
    expect_rsp(2, 8'h99);
    req_valid[2] = 1'b1;
    wait_grant(2);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    wait_drain();

    // All four opcodes on the same operands.
    for (int op = 0; op < 4; op++) begin
      set_req(0, 8'hF0, 8'hCC, 2'(op));
      expect_rsp(0, op_exp[op]);
      req_valid[0] = 1'b1;
      wait_grant(0);
      wait_drain();
    end

    // Backpressure: response held while a second request waits.
    rsp_ready = 1'b0;
    set_req(0, 8'h5A, 8'h33, 2'b01);
    expect_rsp(0, 8'h7B);
    req_valid[0] = 1'b1;
    wait_grant(0);
    set_req(2, 8'h12, 8'h34, 2'b00);
    expect_rsp(2, 8'h10);
    req_valid[2] = 1'b1;
    for (int c = 0; c < 50 && !rsp_valid; c++) @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    d0 = rsp_data;
    i0 = rsp_id;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data_stable", 32'(rsp_data), 32'(d0));
      chk("bp_id_stable",   32'(rsp_id),   32'(i0));
      chk("bp_req_ready",   32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("post_hs_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    wait_drain();

    // Reset while evaluating bit 3 of an XOR.
    set_req(1, 8'hFF, 8'h0F, 2'b10);
    req_valid[1] = 1'b1;
    wait_grant(1);
    repeat (3) @(posedge clk);
    #2 req_valid[3] = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_ready_held", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid[3] = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);

    // Pointer back at 0 after reset: 0 wins over 2.
    grant_q.delete();
    set_req(0, 8'h0F, 8'h55, 2'b11);
    set_req(2, 8'hC3, 8'h81, 2'b01);
    expect_rsp(0, gate(8'h0F, 8'h55, 2'b11));
    expect_rsp(2, gate(8'hC3, 8'h81, 2'b01));
    @(posedge clk);
    #1 req_valid = 4'b0101;
    wait_grants(2);
    chk_grant(0, 0); chk_grant(1, 2);
    wait_drain();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mux_gate_sched.md
# mux_gate_sched

Round-robin scheduler that shares one bit-serial mux-based logic unit among `N_REQ` requesters. Each requester submits two `WIDTH`-bit operands and a 2-bit gate opcode (AND/OR/XOR/XNOR). The scheduler grants one request at a time and evaluates it LSB-first, one bit per cycle, through a single 1-bit gate built only from 2:1 muxes. It then returns the tagged result over a valid/ready response channel. It sits between the gate-exercise front ends and the shared mux datapath.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand/result width, 1..32.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b`  in  N_REQ*WIDTH  operand B; same packing as `req_a`.
- `req_op`  in  N_REQ*2  opcode; requester i occupies `[i*2 +: 2]`. Encoding: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  WIDTH  result word.
- `rsp_id`  out  $clog2(N_REQ)  index of the requester that owns the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Arbiter picks the first requester with `req_valid` set, searching upward from `rr_ptr` with wrap-around.
  - `req_ready` is asserted combinationally for that winner only.
  - A transfer occurs when valid & ready. On that edge, capture A, B, op and id; clear the bit index and result register; set `rr_ptr` to winner+1 mod `N_REQ`; go to BUSY.
  - With no valid requests, stay in IDLE and leave `rr_ptr` unchanged.
- BUSY:
  - `req_ready` is all zero.
  - Each cycle, the gate unit evaluates bit k of A and B. Result bit k is registered, and k increments.
  - After bit `WIDTH-1` is registered, go to DONE.
- Gate unit evaluation (A bit selects):
  - AND = a ? b : 0
  - OR = a ? 1 : b
  - XOR = a ? ~b : b
  - XNOR = a ? b : ~b
  - ~b is itself produced by a mux: b ? 0 : 1.
- DONE:
  - `rsp_valid` = 1. `rsp_data` and `rsp_id` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake, go to IDLE.
  - No new request is accepted in the handshake cycle.
- `req_valid` deasserting while in BUSY or DONE has no effect; operands were already captured.
- A request that is held valid but not granted must remain valid; the scheduler never drops it.
- Reset, any state: FSM → IDLE, `rr_ptr` = 0, bit index = 0. The in-flight operation is discarded and no response is emitted.

## Timing
- Reset values of outputs:
  - `req_ready` = 0 (forced low while `rst` is high).
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
- Latency: a request accepted at edge E0 gives `rsp_valid` high in the cycle after edge E`WIDTH`, i.e. `WIDTH` cycles after acceptance.
- Throughput: at best one result per `WIDTH`+2 cycles (accept, `WIDTH` BUSY cycles, DONE with immediate ready).
- `rsp_data` changes only on entry to DONE; it is undefined-but-stable (last value) outside DONE.
- All outputs are registered except `req_ready`, which is combinational from state, `rr_ptr` and `req_valid`. There is no combinational path from `rsp_ready` to any output.

## Structure
- Shared package `mux_gate_pkg`:
  - opcode localparams `OP_AND`, `OP_OR`, `OP_XOR`, `OP_XNOR`
  - `sched_state_t` enum (IDLE/BUSY/DONE)
  - the `OP_W` = 2 constant
- Sub-module `mux_gate_bit`: the 1-bit, 4-op gate built purely from instances of the existing 2:1 mux. It is instantiated once in the scheduler.
- The arbiter is inline logic: rotate, priority-encode, rotate back.

## Test plan
- Reset mid-BUSY: assert `rst` during bit 3 of an XOR on 0xFF/0x0F → `rsp_valid` stays 0, FSM returns to IDLE, no response afterward, `req_ready` low during reset.
- Single request: requester 2, A=0xA5, B=0x3C, op XOR → `rsp_data`=0x99, `rsp_id`=2, `rsp_valid` rises exactly 8 cycles after the accept edge.
- All four ops: A=0xF0, B=0xCC from requester 0 → AND 0xC0, OR 0xFC, XOR 0x3C, XNOR 0xC3.
- Round-robin: all four requesters valid continuously from reset → grants in order 0,1,2,3,0. With only requesters 1 and 3 valid after a grant to 1 → next grant goes to 3.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in DONE → `rsp_data`/`rsp_id` stable, `req_ready` all zero, and a pending request is accepted only after the response handshake.
